conv2d_channel_mac: RTL and testbench

//  Downstream consumer of the conv2d weight ROM. Accepts one 3x3x3 input window, walks all output

---
 rtl/conv2d_pkg.sv | 40 ++++
 rtl/conv2d_dot27.sv | 73 +++++++
 rtl/conv2d_channel_mac.sv | 142 ++++++++++++++
 tb/tb_conv2d_channel_mac.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
// ----------------------------------------------------------------------------
// conv2d_pkg
//   Shared definitions for the conv2d channel MAC slice: default geometry and
//   widths, the channel-walk FSM state type, and a width-generic saturation
//   helper.
//   Ports: none (package).
// ----------------------------------------------------------------------------
package conv2d_pkg;

    localparam int unsigned DEF_NUM_OUT_CHANNELS = 16;
    localparam int unsigned DEF_KERNEL_ELEMS     = 27;
    localparam int unsigned DEF_DATA_W           = 8;
    localparam int unsigned DEF_WEIGHT_W         = 8;
    localparam int unsigned DEF_BIAS_W           = 16;
    localparam int unsigned DEF_ACC_W            = 24;
    localparam int unsigned DEF_OUT_W            = 16;
    localparam int unsigned DEF_OUT_SHIFT        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_CALC,
        ST_OUT
    } state_t;

    // Clamp a sign-extended value into the signed range of a w-bit result.
    // The caller truncates the return value to w bits.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                               input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/conv2d_dot27.sv
// ----------------------------------------------------------------------------
// conv2d_dot27
//   Two-stage signed dot product with bias. Stage 1 registers every
//   element product plus the bias; stage 2 sums them in one adder tree into a
//   registered accumulator.
//   Ports:
//     clk, rst_n    clock, synchronous active-low reset
//     i_load_prod   capture products and bias (ROM data valid this cycle)
//     i_load_acc    capture sum of products + bias
//     i_win         packed window, element k at [k*DATA_W +: DATA_W]
//     i_weights     packed weights, element k at [k*WEIGHT_W +: WEIGHT_W]
//     i_bias        signed bias
//     o_acc         registered signed accumulator
// ----------------------------------------------------------------------------
module conv2d_dot27
    import conv2d_pkg::*;
#(
    parameter int unsigned KERNEL_ELEMS = DEF_KERNEL_ELEMS,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned WEIGHT_W     = DEF_WEIGHT_W,
    parameter int unsigned BIAS_W       = DEF_BIAS_W,
    parameter int unsigned ACC_W        = DEF_ACC_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_load_prod,
    input  logic                             i_load_acc,
    input  logic [KERNEL_ELEMS*DATA_W-1:0]   i_win,
    input  logic [KERNEL_ELEMS*WEIGHT_W-1:0] i_weights,
    input  logic [BIAS_W-1:0]                i_bias,
    output logic signed [ACC_W-1:0]          o_acc
);

    localparam int unsigned PROD_W = DATA_W + WEIGHT_W;

    logic signed [PROD_W-1:0] r_prod [KERNEL_ELEMS];
    logic signed [BIAS_W-1:0] r_bias;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < KERNEL_ELEMS; k++) begin
                r_prod[k] <= '0;
            end
            r_bias <= '0;
        end else if (i_load_prod) begin
            for (int unsigned k = 0; k < KERNEL_ELEMS; k++) begin
                r_prod[k] <= $signed(i_win[k*DATA_W +: DATA_W]) *
                             $signed(i_weights[k*WEIGHT_W +: WEIGHT_W]);
            end
            r_bias <= $signed(i_bias);
        end
    end

    always_comb begin
        w_sum = ACC_W'(r_bias);
        for (int unsigned k = 0; k < KERNEL_ELEMS; k++) begin
            w_sum = w_sum + ACC_W'(r_prod[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_load_acc) begin
            r_acc <= w_sum;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/conv2d_channel_mac.sv
// ----------------------------------------------------------------------------
// conv2d_channel_mac
//   Accepts one packed 3x3x3 window, then walks every output channel:
//   reads the channel's weights and bias from the weight ROM (1-cycle
//   latency), forms the signed dot product plus bias, arithmetic-shifts and
//   saturates it, and emits one result per channel on a valid/ready stream.
//   Per channel: FETCH, WAIT, CALC, OUT (4 cycles with out_ready high).
//   Build option: define CONV2D_RELU_EN to clamp negative shifted values to 0
//   before saturation.
//   Ports:
//     clk, rst_n     clock, synchronous active-low reset
//     win_valid/win_ready/win_data       window input handshake
//     rom_addr/rom_en                    weight ROM read request (addr = channel)
//     rom_weights/rom_bias               ROM data, valid the cycle after rom_en
//     out_valid/out_ready                result stream handshake
//     out_data/out_channel/out_last      scaled result, channel index, last flag
// ----------------------------------------------------------------------------
module conv2d_channel_mac
    import conv2d_pkg::*;
#(
    parameter int unsigned NUM_OUT_CHANNELS = DEF_NUM_OUT_CHANNELS,
    parameter int unsigned KERNEL_ELEMS     = DEF_KERNEL_ELEMS,
    parameter int unsigned DATA_W           = DEF_DATA_W,
    parameter int unsigned WEIGHT_W         = DEF_WEIGHT_W,
    parameter int unsigned BIAS_W           = DEF_BIAS_W,
    parameter int unsigned ACC_W            = DEF_ACC_W,
    parameter int unsigned OUT_W            = DEF_OUT_W,
    parameter int unsigned OUT_SHIFT        = DEF_OUT_SHIFT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             win_valid,
    output logic                             win_ready,
    input  logic [KERNEL_ELEMS*DATA_W-1:0]   win_data,
    output logic [7:0]                       rom_addr,
    output logic                             rom_en,
    input  logic [KERNEL_ELEMS*WEIGHT_W-1:0] rom_weights,
    input  logic [BIAS_W-1:0]                rom_bias,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_W-1:0]                 out_data,
    output logic [7:0]                       out_channel,
    output logic                             out_last
);

    state_t                          r_state;
    state_t                          w_next;
    logic [7:0]                      r_ch;
    logic [KERNEL_ELEMS*DATA_W-1:0]  r_win;
    logic                            w_last;
    logic                            w_load_prod;
    logic                            w_load_acc;
    logic signed [ACC_W-1:0]         w_acc;
    logic signed [ACC_W-1:0]         w_shift;
    logic signed [ACC_W-1:0]         w_relu;

    assign w_last = (r_ch == 8'(NUM_OUT_CHANNELS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_win   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && win_valid) begin
                r_win <= win_data;
                r_ch  <= '0;
            end else if (r_state == ST_OUT && out_ready && !w_last) begin
                r_ch  <= r_ch + 8'd1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        win_ready   = 1'b0;
        rom_en      = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        w_load_prod = 1'b0;
        w_load_acc  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                win_ready = 1'b1;
                if (win_valid) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                rom_en = 1'b1;
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_load_prod = 1'b1;
                w_next      = ST_CALC;
            end
            ST_CALC: begin
                w_load_acc = 1'b1;
                w_next     = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                out_last  = w_last;
                if (out_ready) w_next = w_last ? ST_IDLE : ST_FETCH;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Channel counter doubles as ROM address; it only changes on window accept
    // or handshake, so the address holds between fetches.
    assign rom_addr    = r_ch;
    assign out_channel = r_ch;

    conv2d_dot27 #(
        .KERNEL_ELEMS (KERNEL_ELEMS),
        .DATA_W       (DATA_W),
        .WEIGHT_W     (WEIGHT_W),
        .BIAS_W       (BIAS_W),
        .ACC_W        (ACC_W)
    ) u_dot (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load_prod (w_load_prod),
        .i_load_acc  (w_load_acc),
        .i_win       (r_win),
        .i_weights   (rom_weights),
        .i_bias      (rom_bias),
        .o_acc       (w_acc)
    );

    // Accumulator only reloads in CALC, so out_data is stable throughout OUT.
    assign w_shift = w_acc >>> OUT_SHIFT;

`ifdef CONV2D_RELU_EN
    assign w_relu = w_shift[ACC_W-1] ? '0 : w_shift;
`else
    assign w_relu = w_shift;
`endif

    assign out_data = OUT_W'(sat(64'(w_relu), OUT_W));

endmodule

// File: tb/tb_conv2d_channel_mac.sv
module tb_conv2d_channel_mac;

    localparam int NCH = 16;
    localparam int KE  = 27;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: 16 channels, shift 8
    logic         rst_n;
    logic         win_valid;
    logic         win_ready;
    logic [215:0] win_data;
    logic [7:0]   rom_addr;
    logic         rom_en;
    logic [215:0] rom_weights;
    logic [15:0]  rom_bias;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [7:0]   out_channel;
    logic         out_last;

    // Second DUT: 1 channel, shift 0 (saturation and single-channel last flag)
    logic         rst_n1;
    logic         win_valid1;
    logic         win_ready1;
    logic [215:0] win_data1;
    logic [7:0]   rom_addr1;
    logic         rom_en1;
    logic [215:0] rom_weights1;
    logic [15:0]  rom_bias1;
    logic         out_valid1;
    logic         out_ready1;
    logic [15:0]  out_data1;
    logic [7:0]   out_channel1;
    logic         out_last1;

    conv2d_channel_mac u_dut (
        .clk(clk), .rst_n(rst_n),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .rom_addr(rom_addr), .rom_en(rom_en),
        .rom_weights(rom_weights), .rom_bias(rom_bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_channel(out_channel), .out_last(out_last)
    );

    conv2d_channel_mac #(
        .NUM_OUT_CHANNELS (1),
        .OUT_SHIFT        (0)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n1),
        .win_valid(win_valid1), .win_ready(win_ready1), .win_data(win_data1),
        .rom_addr(rom_addr1), .rom_en(rom_en1),
        .rom_weights(rom_weights1), .rom_bias(rom_bias1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_channel(out_channel1), .out_last(out_last1)
    );

    int pix [KE];
    int w   [NCH][KE];
    int b   [NCH];
    int w1  [KE];
    int b1;
    int obs [NCH];

    int checks = 0;
    int errors = 0;

    // Weight ROM models: one-cycle registered read.
    always @(posedge clk) begin
        if (rom_en) begin
            for (int k = 0; k < KE; k++) rom_weights[k*8 +: 8] <= 8'(w[rom_addr[3:0]][k]);
            rom_bias <= 16'(b[rom_addr[3:0]]);
        end
    end

    always @(posedge clk) begin
        if (rom_en1) begin
            for (int k = 0; k < KE; k++) rom_weights1[k*8 +: 8] <= 8'(w1[k]);
            rom_bias1 <= 16'(b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs_v,
                       input logic signed [31:0] exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs_v, exp_v);
        end
    endtask

    function automatic logic [215:0] pack_pix();
        logic [215:0] v;
        v = '0;
        for (int k = 0; k < KE; k++) v[k*8 +: 8] = 8'(pix[k]);
        return v;
    endfunction

    // Reference: dot product + bias, floor shift, optional ReLU, 16-bit saturation.
    function automatic int model(input int ch, input int shift);
        int acc;
        acc = b[ch];
        for (int k = 0; k < KE; k++) acc += pix[k] * w[ch][k];
        acc = acc >>> shift;
`ifdef CONV2D_RELU_EN
        if (acc < 0) acc = 0;
`endif
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    // Full window on the main DUT; caller leaves it in IDLE, #1 after an edge.
    // bp_ch: channel held with out_ready=0 for 20 cycles (-1 for none).
    // keep: leave win_valid high throughout (back-to-back windows).
    task automatic run_window(input int bp_ch, input int keep);
        int exp_d;
        chk("idle_win_ready", win_ready, 1);
        win_data  = pack_pix();
        win_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        if (keep == 0) win_valid = 1'b0;
        win_data = '1;  // must be ignored while busy
        for (int ch = 0; ch < NCH; ch++) begin
            exp_d = model(ch, 8);
            chk($sformatf("ch%0d_fetch_en", ch), rom_en, 1);
            chk($sformatf("ch%0d_fetch_addr", ch), rom_addr, ch);
            chk($sformatf("ch%0d_busy_ready", ch), win_ready, 0);
            tick();
            chk($sformatf("ch%0d_wait_en", ch), rom_en, 0);
            chk($sformatf("ch%0d_wait_valid", ch), out_valid, 0);
            if (ch == bp_ch) out_ready = 1'b0;
            tick();
            chk($sformatf("ch%0d_calc_valid", ch), out_valid, 0);
            tick();
            chk($sformatf("ch%0d_out_valid", ch), out_valid, 1);
            chk($sformatf("ch%0d_out_data", ch), $signed(out_data), exp_d);
            chk($sformatf("ch%0d_out_channel", ch), out_channel, ch);
            chk($sformatf("ch%0d_out_last", ch), out_last, (ch == NCH - 1) ? 1 : 0);
            chk($sformatf("ch%0d_out_ready_busy", ch), win_ready, 0);
            obs[ch] = int'($signed(out_data));
            if (ch == bp_ch) begin
                for (int i = 0; i < 20; i++) begin
                    tick();
                    chk("bp_valid", out_valid, 1);
                    chk("bp_data", $signed(out_data), exp_d);
                    chk("bp_channel", out_channel, ch);
                    chk("bp_rom_en", rom_en, 0);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        chk("done_valid", out_valid, 0);
        chk("done_win_ready", win_ready, 1);
    endtask

    // Single-channel DUT, shift 0: one result, always last.
    task automatic run1(input string tag, input int exp_plain, input int exp_relu);
        int exp_v;
`ifdef CONV2D_RELU_EN
        exp_v = exp_relu;
`else
        exp_v = exp_plain;
`endif
        win_data1  = pack_pix();
        win_valid1 = 1'b1;
        out_ready1 = 1'b1;
        tick();
        win_valid1 = 1'b0;
        chk({tag, "_rom_en"}, rom_en1, 1);
        chk({tag, "_rom_addr"}, rom_addr1, 0);
        tick();
        tick();
        chk({tag, "_calc_valid"}, out_valid1, 0);
        tick();
        chk({tag, "_valid"}, out_valid1, 1);
        chk({tag, "_data"}, $signed(out_data1), exp_v);
        chk({tag, "_last"}, out_last1, 1);
        chk({tag, "_channel"}, out_channel1, 0);
        tick();
        chk({tag, "_drop"}, out_valid1, 0);
        chk({tag, "_ready"}, win_ready1, 1);
    endtask

    task automatic set_pix(input int v);
        for (int k = 0; k < KE; k++) pix[k] = v;
    endtask

    task automatic set_w1(input int v, input int bias);
        for (int k = 0; k < KE; k++) w1[k] = v;
        b1 = bias;
    endtask

    initial begin
        for (int ch = 0; ch < NCH; ch++) begin
            for (int k = 0; k < KE; k++) w[ch][k] = ((k * 7 + ch * 11) % 41) - 20;
            b[ch] = (ch - 8) * 300;
        end
        for (int k = 0; k < KE; k++) begin
            w[0][k] = 2;
            w[1][k] = -1;
            w[2][k] = 127;
        end
        b[0] = 256;
        b[1] = 0;
        b[2] = 32767;
        set_w1(0, 0);

        rst_n = 1'b0; win_valid = 1'b0; win_data = '0; out_ready = 1'b1;
        rst_n1 = 1'b0; win_valid1 = 1'b0; win_data1 = '0; out_ready1 = 1'b1;
        tick();
        tick();
        chk("rst_win_ready", win_ready, 1);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_channel", out_channel, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst1_out_last", out_last1, 0);
        rst_n = 1'b1;
        rst_n1 = 1'b1;
        tick();

        // Window A: all pixels 1
        set_pix(1);
        run_window(-1, 0);
        chk("A_ch0_310", obs[0], 1);
`ifdef CONV2D_RELU_EN
        chk("A_ch1_neg", obs[1], 0);
`else
        chk("A_ch1_neg", obs[1], -1);
`endif
        chk("A_ch2", obs[2], 141);

        // Window B: all pixels 127, backpressure on channel 3
        set_pix(127);
        run_window(3, 0);
        chk("B_ch2_1829", obs[2], 1829);
        chk("B_ch0", obs[0], 27);
`ifdef CONV2D_RELU_EN
        chk("B_ch1_floor", obs[1], 0);
`else
        chk("B_ch1_floor", obs[1], -14);
`endif

        // Reset while holding a result in OUT on channel 3
        set_pix(1);
        win_data = pack_pix();
        win_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        win_valid = 1'b0;
        repeat (12) tick();
        out_ready = 1'b0;
        repeat (3) tick();
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_channel", out_channel, 3);
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_win_ready", win_ready, 1);
        chk("midrst_rom_en", rom_en, 0);
        chk("midrst_rom_addr", rom_addr, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_channel", out_channel, 0);
        chk("midrst_out_last", out_last, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // Back-to-back: varied pixels, then all -3, win_valid held high
        for (int k = 0; k < KE; k++) pix[k] = ((k * 13) % 31) - 15;
        run_window(-1, 1);
        set_pix(-3);
        run_window(-1, 0);

        // Single-channel, shift 0: saturation at both ends
        set_pix(1);
        set_w1(2, 256);
        run1("s_310", 310, 310);
        set_pix(127);
        set_w1(127, 32767);
        run1("s_satpos", 32767, 32767);
        set_pix(-128);
        run1("s_satneg", -32768, 0);
        set_pix(1);
        set_w1(-1, 0);
        run1("s_neg27", -27, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
